// File: rtl/ex_writeback_pipe.sv
// EX result path: EX/MEM and MEM/WB pipeline registers, register-file write,
// operand forwarding back to EX and load-use stall detection.
module ex_writeback_pipe #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   alu_outE,
    input  logic [AW-1:0]   r3_addrE,
    input  logic            RegWriteE,
    input  logic            MemtoRegE,
    input  logic            flushE,
    input  logic            stallM,
    input  logic [DW-1:0]   mem_rdataM,
    input  logic [AW-1:0]   rsD,
    input  logic [AW-1:0]   rtD,
    input  logic [AW-1:0]   rsE,
    input  logic [AW-1:0]   rtE,
    input  logic [DW-1:0]   r1_regE,
    input  logic [DW-1:0]   r2_regE,
    output logic [DW-1:0]   r1_doutE,
    output logic [DW-1:0]   r2_doutE,
    output logic [DW-1:0]   alu_outM,
    output logic [AW-1:0]   r3_addrM,
    output logic            RegWriteM,
    output logic            MemtoRegM,
    output logic [AW-1:0]   r3_addrW,
    output logic [DW-1:0]   resultW,
    output logic            RegWriteW,
    output logic            lu_stall,
    output logic [CNTW-1:0] retire_cnt
);

    logic [DW-1:0] alu_outW;
    logic [DW-1:0] mem_dataW;
    logic          MemtoRegW;

    // MEM stage: a memory stall holds everything, even over a pending flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_outM  <= '0;
            r3_addrM  <= '0;
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
        end else if (!stallM) begin
            if (flushE) begin
                alu_outM  <= '0;
                r3_addrM  <= '0;
                RegWriteM <= 1'b0;
                MemtoRegM <= 1'b0;
            end else begin
                alu_outM  <= alu_outE;
                r3_addrM  <= r3_addrE;
                RegWriteM <= RegWriteE;
                MemtoRegM <= MemtoRegE;
            end
        end
    end

    // WB stage: while MEM is held only a bubble advances, so each write happens once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_outW  <= '0;
            mem_dataW <= '0;
            r3_addrW  <= '0;
            MemtoRegW <= 1'b0;
            RegWriteW <= 1'b0;
        end else if (stallM) begin
            RegWriteW <= 1'b0;
        end else begin
            alu_outW  <= alu_outM;
            mem_dataW <= mem_rdataM;
            r3_addrW  <= r3_addrM;
            MemtoRegW <= MemtoRegM;
            RegWriteW <= RegWriteM && (r3_addrM != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (RegWriteW) begin
            retire_cnt <= retire_cnt + CNTW'(1);
        end
    end

    assign resultW = MemtoRegW ? mem_dataW : alu_outW;

    // A load still in MEM has no data yet, so it is never a forwarding source
    always_comb begin
        r1_doutE = r1_regE;
        r2_doutE = r2_regE;
        if (rsE != '0) begin
            if (RegWriteM && !MemtoRegM && (r3_addrM != '0) && (r3_addrM == rsE)) begin
                r1_doutE = alu_outM;
            end else if (RegWriteW && (r3_addrW == rsE)) begin
                r1_doutE = resultW;
            end
        end
        if (rtE != '0) begin
            if (RegWriteM && !MemtoRegM && (r3_addrM != '0) && (r3_addrM == rtE)) begin
                r2_doutE = alu_outM;
            end else if (RegWriteW && (r3_addrW == rtE)) begin
                r2_doutE = resultW;
            end
        end
    end

    assign lu_stall = RegWriteE && MemtoRegE && (r3_addrE != '0) &&
                      ((r3_addrE == rsD) || (r3_addrE == rtD));

endmodule

// File: tb/tb_ex_writeback_pipe.sv
// Directed bench for ex_writeback_pipe: expected register-file writes are
// queued when EX instructions are driven and checked as they reach WB.
module tb_ex_writeback_pipe;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CNTW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   alu_outE = '0;
    logic [AW-1:0]   r3_addrE = '0;
    logic            RegWriteE = 1'b0;
    logic            MemtoRegE = 1'b0;
    logic            flushE = 1'b0;
    logic            stallM = 1'b0;
    logic [DW-1:0]   mem_rdataM = '0;
    logic [AW-1:0]   rsD = '0;
    logic [AW-1:0]   rtD = '0;
    logic [AW-1:0]   rsE = '0;
    logic [AW-1:0]   rtE = '0;
    logic [DW-1:0]   r1_regE = '0;
    logic [DW-1:0]   r2_regE = '0;
    logic [DW-1:0]   r1_doutE;
    logic [DW-1:0]   r2_doutE;
    logic [DW-1:0]   alu_outM;
    logic [AW-1:0]   r3_addrM;
    logic            RegWriteM;
    logic            MemtoRegM;
    logic [AW-1:0]   r3_addrW;
    logic [DW-1:0]   resultW;
    logic            RegWriteW;
    logic            lu_stall;
    logic [CNTW-1:0] retire_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    wr_t         exp_q[$];

    ex_writeback_pipe #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .alu_outE(alu_outE), .r3_addrE(r3_addrE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .flushE(flushE), .stallM(stallM),
        .mem_rdataM(mem_rdataM), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .r1_regE(r1_regE), .r2_regE(r2_regE), .r1_doutE(r1_doutE),
        .r2_doutE(r2_doutE), .alu_outM(alu_outM), .r3_addrM(r3_addrM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .r3_addrW(r3_addrW),
        .resultW(resultW), .RegWriteW(RegWriteW), .lu_stall(lu_stall),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Any WB write must match the oldest queued expectation; none may appear unannounced
    task automatic check_wb();
        wr_t e;
        if (RegWriteW === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, r3_addrW, resultW}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 64'(r3_addrW), 64'(e.addr));
                check("wb_data", 64'(resultW), 64'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic drive_e(input logic [DW-1:0] alu, input logic [AW-1:0] addr,
                           input logic rw, input logic m2r);
        alu_outE  = alu;
        r3_addrE  = addr;
        RegWriteE = rw;
        MemtoRegE = m2r;
    endtask

    task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset state
        rsE = 5'd3; r1_regE = 32'h1234; rtE = 5'd4; r2_regE = 32'h5678;
        tick();
        tick();
        check("rst_regwrite_w", 64'(RegWriteW), 64'd0);
        check("rst_result_w", 64'(resultW), 64'd0);
        check("rst_addr_w", 64'(r3_addrW), 64'd0);
        check("rst_retire", 64'(retire_cnt), 64'd0);
        check("rst_regwrite_m", 64'(RegWriteM), 64'd0);
        check("rst_fwd_a", 64'(r1_doutE), 64'h1234);
        check("rst_fwd_b", 64'(r2_doutE), 64'h5678);
        rst = 1'b0;

        // ALU chain: r5 then r6, consumer of r5 forwards from M then W
        drive_e(32'h11, 5'd5, 1'b1, 1'b0); expect_write(5'd5, 32'h11);
        tick();
        rsE = 5'd5; r1_regE = 32'hDEAD; rtE = 5'd0; r2_regE = 32'h77;
        drive_e(32'h22, 5'd6, 1'b1, 1'b0); expect_write(5'd6, 32'h22);
        #1;
        check("chain_fwd_m", 64'(r1_doutE), 64'h11);
        check("chain_rt0", 64'(r2_doutE), 64'h77);
        check("chain_alu_m", 64'(alu_outM), 64'h11);
        tick();
        check("chain_w_valid", 64'(RegWriteW), 64'd1);
        check("chain_fwd_w", 64'(r1_doutE), 64'h11);
        drive_e('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check("chain_retire", 64'(retire_cnt), 64'd2);

        // Load-use: load r8 in EX, decode reads r8
        drive_e(32'h100, 5'd8, 1'b1, 1'b1); rsD = 5'd8; rtD = 5'd0;
        #1;
        check("lu_rs", 64'(lu_stall), 64'd1);
        rsD = 5'd9; rtD = 5'd8; #1;
        check("lu_rt", 64'(lu_stall), 64'd1);
        rtD = 5'd9; #1;
        check("lu_none", 64'(lu_stall), 64'd0);
        expect_write(5'd8, 32'hCAFE);
        tick();
        flushE = 1'b1; drive_e(32'h99, 5'd8, 1'b1, 1'b0);
        mem_rdataM = 32'hCAFE; rsE = 5'd8; r1_regE = 32'h1;
        #1;
        check("lu_no_fwd_load_m", 64'(r1_doutE), 64'h1);
        tick();
        flushE = 1'b0; drive_e('0, '0, 1'b0, 1'b0); mem_rdataM = 32'hBAD;
        #1;
        check("lu_fwd_w", 64'(r1_doutE), 64'hCAFE);
        check("lu_result_w", 64'(resultW), 64'hCAFE);
        check("lu_flush_bubble", 64'(RegWriteM), 64'd0);
        tick();
        tick();
        check("lu_retire", 64'(retire_cnt), 64'd3);

        // Stall with flush pending: M held, W bubbles, single write afterwards
        drive_e(32'h44, 5'd9, 1'b1, 1'b0); expect_write(5'd9, 32'h44);
        tick();
        stallM = 1'b1; flushE = 1'b1; drive_e(32'h66, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_w_idle", 64'(RegWriteW), 64'd0);
            check("stall_m_held", 64'({r3_addrM, alu_outM}), 64'({5'd9, 32'h44}));
        end
        stallM = 1'b0; flushE = 1'b0; drive_e('0, '0, 1'b0, 1'b0);
        tick();
        check("stall_one_write", 64'(RegWriteW), 64'd1);
        tick();
        check("stall_after", 64'(RegWriteW), 64'd0);
        check("stall_retire", 64'(retire_cnt), 64'd4);

        // r0 is never written and never forwarded
        drive_e(32'h55, 5'd0, 1'b1, 1'b1); rsD = 5'd0; rtD = 5'd0; #1;
        check("r0_no_lu", 64'(lu_stall), 64'd0);
        drive_e(32'h55, 5'd0, 1'b1, 1'b0);
        tick();
        rsE = 5'd0; r1_regE = 32'h3; drive_e('0, '0, 1'b0, 1'b0);
        #1;
        check("r0_fwd_m", 64'(r1_doutE), 64'h3);
        tick();
        check("r0_no_write", 64'(RegWriteW), 64'd0);
        check("r0_fwd_w", 64'(r1_doutE), 64'h3);

        // Priority: M (0xA) beats W (0xB) for the same register
        drive_e(32'hB, 5'd3, 1'b1, 1'b0); expect_write(5'd3, 32'hB);
        tick();
        drive_e(32'hA, 5'd3, 1'b1, 1'b0); expect_write(5'd3, 32'hA);
        tick();
        rsE = 5'd3; rtE = 5'd3; r1_regE = 32'hF0; r2_regE = 32'hF1;
        drive_e('0, '0, 1'b0, 1'b0);
        #1;
        check("prio_fwd_a", 64'(r1_doutE), 64'hA);
        check("prio_fwd_b", 64'(r2_doutE), 64'hA);
        tick();
        check("prio_w_only", 64'(r2_doutE), 64'hA);
        tick();
        check("prio_retire", 64'(retire_cnt), 64'd6);

        // Reset mid-stream discards in-flight writes
        drive_e(32'h77, 5'd4, 1'b1, 1'b0); expect_write(5'd4, 32'h77);
        tick();
        drive_e(32'h78, 5'd7, 1'b1, 1'b0);
        tick();
        drive_e('0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_regwrite_w", 64'(RegWriteW), 64'd0);
        check("mid_rst_result_w", 64'(resultW), 64'd0);
        check("mid_rst_retire", 64'(retire_cnt), 64'd0);
        check("mid_rst_regwrite_m", 64'(RegWriteM), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_idle", 64'(RegWriteW), 64'd0);
        check("post_rst_retire", 64'(retire_cnt), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
